csi2_packet_ctrl: RTL
=====================

# csi2_packet_ctrl

Packet sequencer for the 2-lane CSI-2 receive path. It sits directly after the lane deskew/merge stage and consumes its 16-bit word stream. It parses the 4-byte packet header, then counts payload and CRC words and forwards payload as a byte-enabled word stream. It generates `packet_done`, which tells the lane stage to drop `word_vld` and re-arm for the next SoT, and it also reports frame/line events and protocol errors.

## Interface
Parameters:
- `MAX_WC`, 16'd4096: largest accepted long-packet word count, in bytes.

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `word_data`, in, 16: merged lane word; [7:0] is the lane0 byte (earlier byte), [15:8] is the lane1 byte.
- `word_vld`, in, 1: high from the first packet word until the cycle after `packet_done`; one word per high cycle.
- `invalid_start`, in, 1: pulse from the lane stage on a skewed SoT.
- `packet_done`, out, 1: last word of the current packet is on `word_data` this cycle.
- `hdr_vld`, out, 1: pulse; header fields are valid.
- `hdr_di`, out, 8: data identifier, {VC[1:0], DT[5:0]}.
- `hdr_wc`, out, 16: word count or short-packet data field.
- `hdr_ecc`, out, 8: header ECC byte, passed through unchecked.
- `pay_data`, out, 16: payload word.
- `pay_be`, out, 2: byte enables for `pay_data`.
- `pay_vld`, out, 1: `pay_data` is valid.
- `pay_last`, out, 1: last payload word of the packet.
- `frame_start`, out, 1: pulse on an FS (DT 0x00) short packet.
- `frame_end`, out, 1: pulse on an FE (DT 0x01) short packet.
- `line_cnt`, out, 16: number of long packets with WC>0 since the last FS.
- `err_invalid_start`, out, 1: pulse.
- `err_wc_overflow`, out, 1: pulse.
- `err_truncated`, out, 1: pulse.
- `busy`, out, 1: state is not IDLE.

## Operation
- Header byte mapping:
  - word0 = {WC[7:0], DI}.
  - word1 = {ECC, WC[15:8]}.
- FSM states: IDLE, HDR1, PAYLOAD.
  - IDLE → HDR1 on `word_vld`; latch DI and WC[7:0].
  - HDR1, with `word_vld`:
    - Latch WC[15:8] and ECC; pulse `hdr_vld`.
    - Short packet (DT < 0x10): `packet_done` asserted; go to IDLE.
    - Long packet with WC > MAX_WC: `packet_done` asserted, `err_wc_overflow` pulse, no payload; go to IDLE.
    - Otherwise go to PAYLOAD; word counter k = 0.
  - PAYLOAD: total words N = ceil((WC+2)/2), covering WC payload bytes plus the 2-byte CRC. Compute with 17-bit arithmetic.
    - Word k carries bytes 2k and 2k+1. Byte b is payload iff b < WC.
    - `pay_vld` for k < ceil(WC/2); `pay_be` = {2k+1<WC, 2k<WC}; `pay_last` at k = ceil(WC/2)-1.
    - CRC bytes are dropped, never forwarded.
    - `packet_done` at k = N-1; go to IDLE.
    - WC = 0 gives N = 1 (CRC only) and no `pay_vld`.
  - `word_vld` low in HDR1 or PAYLOAD: `err_truncated` pulse; go to IDLE; `pay_last` is not generated.
- Frame/line tracking:
  - FS (DT 0x00) pulses `frame_start` and clears `line_cnt`.
  - FE (DT 0x01) pulses `frame_end`.
  - `line_cnt` increments (wrapping at 16 bits) at `hdr_vld` of any accepted long packet with WC > 0.
- `invalid_start` pulses `err_invalid_start` one cycle later, in any state. The FSM is not affected.
- Reset values: all outputs 0, state IDLE, header registers 0.

## Timing
- `packet_done` is a Moore decode of state/counter, gated by `word_vld`. It is high in the same cycle as the last word, so the lane stage clears `word_vld` at the next edge.
- No gap is required between packets; IDLE accepts a new word0 in the cycle after `word_vld` falls.
- `hdr_vld`, `frame_start`, `frame_end`:
  - registered;
  - 1 cycle after word1;
  - high for exactly 1 cycle.
- `pay_*`: registered, 1 cycle after the corresponding `word_data`.
- All `err_*` outputs: registered, 1-cycle pulses.
- `resetn` asserted mid-packet: immediate IDLE, all outputs cleared.
- `word_vld` high in IDLE without a preceding fall: treated as a new packet start.

## Structure
- Shared package `mipi_csi2_pkg`:
  - DT constants: FS 0x00, FE 0x01, LS 0x02, LE 0x03, SHORT_MAX 0x0F;
  - FSM state enum;
  - header byte index constants.
- Single module with no sub-module. ECC and CRC checking belong to separate downstream blocks.

## Test plan
- Short FS: words 0x0000, 0xXX00 → `packet_done` on the 2nd word; `hdr_vld` and `frame_start` pulse; `line_cnt` = 0.
- Long packet DI 0x2B, WC = 6: header words 0x062B, 0xEE00; 3 payload words → `pay_be` = 11, 11, 11, `pay_last` on the 3rd; CRC word dropped; `packet_done` on word 4 of the payload stage.
- Odd WC = 5 → 3 payload words, last with `pay_be` = 01; the CRC straddles words → N = 4; `packet_done` on the 4th payload-stage word.
- WC = 0x2000 with MAX_WC = 4096 → `err_wc_overflow` pulse, `packet_done` on word1, no `pay_vld`.
- `word_vld` drops after 2 of 4 payload words → `err_truncated` pulse, IDLE; a following FS packet parses correctly.
- `invalid_start` pulse during PAYLOAD → `err_invalid_start` one cycle later; payload count unaffected. `resetn` low mid-packet → all outputs 0 and `busy` = 0.

Source files
------------

// File: rtl/mipi_csi2_pkg.sv
// Shared CSI-2 receive-path definitions: data-type codes, sequencer states
// and the byte positions of the packet header within the two header words.
package mipi_csi2_pkg;

  // Data-type codes used by the packet sequencer
  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

  // Header byte positions: word0 = {WC[7:0], DI}, word1 = {ECC, WC[15:8]}
  localparam int HDR_W0_DI_LSB   = 0;
  localparam int HDR_W0_WCLO_LSB = 8;
  localparam int HDR_W1_WCHI_LSB = 0;
  localparam int HDR_W1_ECC_LSB  = 8;

  // Packet sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR1    = 2'd1,
    ST_PAYLOAD = 2'd2
  } pkt_state_e;

  // Short packets carry data types 0x00..0x0F
  function automatic logic is_short_dt(input logic [5:0] dt);
    return (dt <= DT_SHORT_MAX);
  endfunction

endpackage

// File: rtl/csi2_packet_ctrl.sv
// CSI-2 packet sequencer: parses the 4-byte header from the merged 16-bit
// lane stream, forwards payload bytes with byte enables, drops the CRC,
// tracks frame/line events and flags protocol errors.
module csi2_packet_ctrl
  import mipi_csi2_pkg::*;
#(
  parameter logic [15:0] MAX_WC = 16'd4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] word_data,
  input  logic        word_vld,
  input  logic        invalid_start,
  output logic        packet_done,
  output logic        hdr_vld,
  output logic [7:0]  hdr_di,
  output logic [15:0] hdr_wc,
  output logic [7:0]  hdr_ecc,
  output logic [15:0] pay_data,
  output logic [1:0]  pay_be,
  output logic        pay_vld,
  output logic        pay_last,
  output logic        frame_start,
  output logic        frame_end,
  output logic [15:0] line_cnt,
  output logic        err_invalid_start,
  output logic        err_wc_overflow,
  output logic        err_truncated,
  output logic        busy
);

  pkt_state_e  state_q;
  logic [15:0] k_q;
  logic [7:0]  hdr_di_q;
  logic [15:0] hdr_wc_q;
  logic [7:0]  hdr_ecc_q;
  logic        hdr_vld_q;
  logic        frame_start_q;
  logic        frame_end_q;
  logic [15:0] line_cnt_q;
  logic [15:0] pay_data_q;
  logic [1:0]  pay_be_q;
  logic        pay_vld_q;
  logic        pay_last_q;
  logic        err_inv_q;
  logic        err_ovf_q;
  logic        err_trunc_q;
  logic        packet_done_d;

  // Header word1 decode: full word count is only known while word1 is present
  logic [15:0] wc_full_s;
  logic [5:0]  dt_s;
  logic        short_s;
  logic        ovf_s;
  assign wc_full_s = {word_data[HDR_W1_WCHI_LSB +: 8], hdr_wc_q[7:0]};
  assign dt_s      = hdr_di_q[5:0];
  assign short_s   = is_short_dt(dt_s);
  assign ovf_s     = !short_s && (wc_full_s > MAX_WC);

  // Payload-stage bookkeeping in 17 bits so WC near 0xFFFF cannot wrap
  logic [16:0] n_words_s;
  logic [16:0] n_pay_s;
  logic [16:0] k_ext_s;
  logic        k_last_s;
  logic        k_pay_s;
  logic        k_pay_last_s;
  logic [1:0]  be_s;
  assign n_words_s    = ({1'b0, hdr_wc_q} + 17'd3) >> 1;
  assign n_pay_s      = ({1'b0, hdr_wc_q} + 17'd1) >> 1;
  assign k_ext_s      = {1'b0, k_q};
  assign k_last_s     = (k_ext_s == (n_words_s - 17'd1));
  assign k_pay_s      = (k_ext_s < n_pay_s);
  assign k_pay_last_s = (k_ext_s == (n_pay_s - 17'd1));
  assign be_s[0]      = ({k_q, 1'b0} < {1'b0, hdr_wc_q});
  assign be_s[1]      = ({k_q, 1'b1} < {1'b0, hdr_wc_q});

  // Last word of the packet is on the bus: state/counter decode gated by word_vld
  always_comb begin
    packet_done_d = 1'b0;
    case (state_q)
      ST_HDR1: begin
        if (word_vld && (short_s || ovf_s)) begin
          packet_done_d = 1'b1;
        end else begin
          packet_done_d = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        if (word_vld && k_last_s) begin
          packet_done_d = 1'b1;
        end else begin
          packet_done_d = 1'b0;
        end
      end
      default: packet_done_d = 1'b0;
    endcase
  end

  // Packet FSM with header latching, payload forwarding and event pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      k_q           <= 16'd0;
      hdr_di_q      <= 8'd0;
      hdr_wc_q      <= 16'd0;
      hdr_ecc_q     <= 8'd0;
      hdr_vld_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      line_cnt_q    <= 16'd0;
      pay_data_q    <= 16'd0;
      pay_be_q      <= 2'b00;
      pay_vld_q     <= 1'b0;
      pay_last_q    <= 1'b0;
      err_inv_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_trunc_q   <= 1'b0;
    end else begin
      hdr_vld_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      pay_vld_q     <= 1'b0;
      pay_be_q      <= 2'b00;
      pay_last_q    <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_trunc_q   <= 1'b0;
      err_inv_q     <= invalid_start;
      case (state_q)
        ST_IDLE: begin
          if (word_vld) begin
            hdr_di_q <= word_data[HDR_W0_DI_LSB +: 8];
            hdr_wc_q <= {8'h00, word_data[HDR_W0_WCLO_LSB +: 8]};
            state_q  <= ST_HDR1;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_HDR1: begin
          if (word_vld) begin
            hdr_wc_q      <= wc_full_s;
            hdr_ecc_q     <= word_data[HDR_W1_ECC_LSB +: 8];
            hdr_vld_q     <= 1'b1;
            frame_start_q <= (dt_s == DT_FS);
            frame_end_q   <= (dt_s == DT_FE);
            if (dt_s == DT_FS) begin
              line_cnt_q <= 16'd0;
            end else if (!short_s && !ovf_s && (wc_full_s != 16'd0)) begin
              line_cnt_q <= line_cnt_q + 16'd1;
            end else begin
              line_cnt_q <= line_cnt_q;
            end
            if (short_s) begin
              state_q <= ST_IDLE;
            end else if (ovf_s) begin
              err_ovf_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              k_q     <= 16'd0;
              state_q <= ST_PAYLOAD;
            end
          end else begin
            err_trunc_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          if (word_vld) begin
            if (k_pay_s) begin
              pay_data_q <= word_data;
              pay_vld_q  <= 1'b1;
              pay_be_q   <= be_s;
              pay_last_q <= k_pay_last_s;
            end else begin
              pay_data_q <= pay_data_q;
            end
            k_q <= k_q + 16'd1;
            if (k_last_s) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_PAYLOAD;
            end
          end else begin
            err_trunc_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign packet_done       = packet_done_d;
  assign hdr_vld           = hdr_vld_q;
  assign hdr_di            = hdr_di_q;
  assign hdr_wc            = hdr_wc_q;
  assign hdr_ecc           = hdr_ecc_q;
  assign pay_data          = pay_data_q;
  assign pay_be            = pay_be_q;
  assign pay_vld           = pay_vld_q;
  assign pay_last          = pay_last_q;
  assign frame_start       = frame_start_q;
  assign frame_end         = frame_end_q;
  assign line_cnt          = line_cnt_q;
  assign err_invalid_start = err_inv_q;
  assign err_wc_overflow   = err_ovf_q;
  assign err_truncated     = err_trunc_q;
  assign busy              = (state_q != ST_IDLE);

endmodule
